serdes_rx_decrypt: RTL and testbench



---
 rtl/serdes_rx_decrypt.sv | 145 ++++++++++++++
 tb/tb_serdes_rx_decrypt.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_rx_decrypt.sv
// serdes_rx_decrypt
//   Receives the MSB-first serial stream of the upstream FIR/XOR-encrypt
//   stage, rebuilds each 8-bit frame on the upstream done pulse, strips the
//   XOR key and queues the recovered byte in a small FIFO that a consumer
//   drains with a valid/ready handshake. Short frames and FIFO overflow
//   raise sticky flags.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   ena        block enable; low discards any partial frame
//   ser_in     serial data, MSB first
//   done_in    one-cycle end-of-frame pulse
//   m_data     decrypted byte at FIFO head
//   m_valid    FIFO non-empty
//   m_ready    consumer accepts the head byte
//   short_err  sticky: done seen with fewer than 8 bits sampled
//   overflow   sticky: a frame was dropped because the FIFO was full
//   frame_cnt  bytes pushed into the FIFO, wraps at 256
module serdes_rx_decrypt #(
  parameter logic [7:0] KEY   = 8'hA5,
  parameter int         DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       ser_in,
  input  logic       done_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       short_err,
  output logic       overflow,
  output logic [7:0] frame_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic frame_end;
  logic push_req;
  logic short_req;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // done_in only counts while actively shifting; the first enabled cycle
  // after idle is a pure transition and ignores done_in.
  assign frame_end = ena && (state == S_SHIFT) && done_in;
  assign push_req  = frame_end && (bit_cnt == 4'd8);
  assign short_req = frame_end && (bit_cnt != 4'd8);

  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign pop     = m_valid && m_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push    = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Frame assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (!ena) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (done_in) begin
            bit_cnt <= '0;
          end else begin
            shreg   <= {shreg[6:0], ser_in};
            // Saturate so idle gaps longer than a byte keep the count at 8;
            // only the last eight samples survive in shreg anyway.
            bit_cnt <= (bit_cnt == 4'd8) ? 4'd8 : bit_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      short_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (short_req) short_err <= 1'b1;
      if (drop)      overflow  <= 1'b1;
    end
  end

  // FIFO storage; cleared on reset so m_data reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= shreg ^ KEY;
    end
  end

  // FIFO pointers, occupancy and push counter. DEPTH is a power of two so
  // pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_rx_decrypt.sv
module tb_serdes_rx_decrypt;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       ser_in;
  logic       done_in;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       short_err;
  logic       overflow;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] KEY = 8'hA5;

  serdes_rx_decrypt #(.KEY(KEY), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ser_in(ser_in), .done_in(done_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .short_err(short_err), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_in  = b;
    done_in = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_done();
    ser_in  = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b);
    send_done();
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; ser_in = 1'b0; done_in = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ser_in  = 1'($urandom);
      done_in = 1'($urandom);
      tick();
    end
    rst = 1'b0; ena = 1'b0; ser_in = 1'b0; done_in = 1'b0;
    n_checks++;
    if ({m_data, m_valid, short_err, overflow, frame_cnt} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset: m_data=%h m_valid=%b short=%b ovf=%b cnt=%0d, want all 0",
               m_data, m_valid, short_err, overflow, frame_cnt);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    ena = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_bit(1'b0);
    send_frame(8'h99);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h3C) begin
      n_errors++;
      $display("FAIL single_data: valid=%b data=%h, want 1 3c", m_valid, m_data);
    end
    n_checks++;
    if (frame_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL single_cnt: got %0d want 1", frame_cnt);
    end
    tick();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_pop: m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    ena = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_done();
    n_checks++;
    if (m_valid !== 1'b0 || short_err !== 1'b1) begin
      n_errors++;
      $display("FAIL short_flag: valid=%b short=%b, want 0 1", m_valid, short_err);
    end
    send_frame(8'hA5);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h00 || short_err !== 1'b1) begin
      n_errors++;
      $display("FAIL short_next: valid=%b data=%h short=%b, want 1 00 1",
               m_valid, m_data, short_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ena = 1'b1;
    send_bit(1'b0); send_bit(1'b0);
    for (int i = 1; i <= 4; i++) send_frame(8'(i) ^ KEY);
    n_checks++;
    if (overflow !== 1'b0 || frame_cnt !== 8'd4) begin
      n_errors++;
      $display("FAIL ovf_pre: ovf=%b cnt=%0d, want 0 4", overflow, frame_cnt);
    end
    send_frame(8'h05 ^ KEY);
    n_checks++;
    if (overflow !== 1'b1 || frame_cnt !== 8'd4) begin
      n_errors++;
      $display("FAIL ovf_set: ovf=%b cnt=%0d, want 1 4", overflow, frame_cnt);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_errors++;
        $display("FAIL ovf_drain%0d: valid=%b data=%h, want 1 %h", i, m_valid, m_data, 8'(i));
      end
      tick();
    end
    n_checks++;
    if (m_valid !== 1'b0 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_empty: valid=%b ovf=%b, want 0 1", m_valid, overflow);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    ena = 1'b1;
    send_bit(1'b0); send_bit(1'b0);
    for (int i = 1; i <= 4; i++) send_frame(8'(i) ^ KEY);
    send_bits(8'h05 ^ KEY);
    m_ready = 1'b1;
    send_done();
    m_ready = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || frame_cnt !== 8'd5) begin
      n_errors++;
      $display("FAIL fullpp_flags: ovf=%b cnt=%0d, want 0 5", overflow, frame_cnt);
    end
    m_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_errors++;
        $display("FAIL fullpp_drain%0d: valid=%b data=%h, want 1 %h", i, m_valid, m_data, 8'(i));
      end
      tick();
    end
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL fullpp_empty: m_valid=%b want 0", m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_ena_drop();
    do_reset();
    ena = 1'b1;
    send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    ena = 1'b0;
    send_bit(1'b0);
    send_done();
    send_bit(1'b0);
    ena = 1'b1;
    send_bit(1'b0); send_bit(1'b0);
    send_frame(8'h5A);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hFF || frame_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL ena_data: valid=%b data=%h cnt=%0d, want 1 ff 1", m_valid, m_data, frame_cnt);
    end
    n_checks++;
    if (short_err !== 1'b0) begin
      n_errors++;
      $display("FAIL ena_short: short=%b want 0", short_err);
    end
    m_ready = 1'b1;
    tick();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ena_only_one: m_valid=%b want 0", m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    ena = 1'b1;
    send_bit(1'b0);
    send_frame(8'h12);
    send_frame(8'h34);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_done();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({m_data, m_valid, short_err, overflow, frame_cnt} !== 19'd0) begin
      n_errors++;
      $display("FAIL midreset: m_data=%h m_valid=%b short=%b ovf=%b cnt=%0d, want all 0",
               m_data, m_valid, short_err, overflow, frame_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    ena = 1'b1; m_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 256; i++) send_frame(8'(i));
    n_checks++;
    if (frame_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL cnt_wrap: cnt=%0d ovf=%b, want 0 0", frame_cnt, overflow);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; ser_in = 1'b0; done_in = 1'b0; m_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_short_frame();
    test_overflow();
    test_full_push_pop();
    test_ena_drop();
    test_reset_midframe();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
